apb_req_scheduler: RTL and testbench
====================================

Name: apb_req_scheduler

Overview:
- Front-end controller that shares the single APB_bus master command port between REQ_NUM on-chip requesters (CPU port, DMA, …).
- Round-robin arbitration picks one request at a time. The block decodes the address to the GPIO/UART one-hot select and sequences the Transfer pulse into the master.
- It watches PENABLE/PREADY for completion and returns read data and error to the granted requester.
- Sits between the requesters and APB_bus; owns all APB_bus command inputs.

Parameters:
- DATA_WIDTH, 32, data width.
- ADDR_WIDTH, 32, address width.
- STROBE_WIDTH, 4, byte strobe width (DATA_WIDTH/8).
- SLAVES_NUM, 2, APB slaves; bit0 = GPIO, bit1 = UART.
- REQ_NUM, 2, number of requesters.
- REGION_BITS, 12, size of each slave window in address bits (4 KiB).
- GPIO_BASE, 32'h0000_0000, GPIO window base.
- UART_BASE, 32'h0000_1000, UART window base.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  REQ_NUM  per-requester request.
- req_ready  out  REQ_NUM  one-cycle grant/accept pulse.
- req_addr  in  REQ_NUM*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  REQ_NUM*DATA_WIDTH  packed write data.
- req_write  in  REQ_NUM  1 = write.
- req_strb  in  REQ_NUM*STROBE_WIDTH  packed byte strobes.
- req_prot  in  REQ_NUM*3  packed protection.
- rsp_valid  out  REQ_NUM  one-cycle response pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  shared read data, valid with rsp_valid.
- rsp_err  out  1  shared error flag, valid with rsp_valid.
- ADDR_in  out  ADDR_WIDTH  APB_bus command address.
- DATA_in  out  DATA_WIDTH  APB_bus write data.
- PROT_in  out  3  APB_bus protection.
- SEL_in  out  SLAVES_NUM  one-hot slave select.
- STROB_in  out  STROBE_WIDTH  APB_bus strobes (forced 0 on reads).
- WRITE_in  out  1  APB_bus direction.
- Transfer  out  1  APB_bus start pulse.
- PENABLE  in  1  monitored from APB_bus.
- PREADY  in  1  monitored slave ready.
- DATA_out  in  DATA_WIDTH  APB_bus read data.
- SLVERR_out  in  1  APB_bus error.

Behaviour:
- Reset (sync, PRESET=1 at PCLK edge): state IDLE, rr pointer=0 (requester 0 has top priority), all outputs 0.
- Reset mid-operation aborts the outstanding transaction silently; no rsp_valid is issued for it.
- FSM IDLE:
  - If any req_valid, grant the first set bit at or after rr_ptr, searching upward with wrap.
  - Pulse req_ready[g] and register addr/wdata/write/strb/prot of requester g.
  - Set rr_ptr = (g+1) mod REQ_NUM.
  - Decode the registered address. Hit → ISSUE; miss (neither window) → RESP with err.
- Decode rule: slave k hits when addr[ADDR_WIDTH-1:REGION_BITS] == BASE_k[ADDR_WIDTH-1:REGION_BITS]. The result is one-hot SEL_in; overlapping bases are illegal.
- ISSUE: Transfer=1 for exactly one cycle; command outputs driven from the registers. Next state WAIT.
- WAIT: Transfer=0; command outputs held stable. On the cycle PENABLE && PREADY is sampled 1:
  - capture DATA_out (reads only; writes capture 0) and SLVERR_out;
  - go to RESP.
  - PREADY low extends WAIT indefinitely.
- RESP: rsp_valid[g]=1 for one cycle with rsp_rdata and rsp_err; then IDLE.
  - On a decode miss: rsp_err=1, rsp_rdata=0, and Transfer is never asserted.
- Outside ISSUE/WAIT: SEL_in=0. On reads, STROB_in=0 and DATA_in=0.
- Latency (hit, PREADY=1): req_valid seen in IDLE at cycle 0 → Transfer cycle 1 → SETUP 2 → ACCESS 3 → rsp_valid cycle 4.
  - Miss: rsp_valid cycle 1.
  - Earliest next grant: the cycle after RESP.
- Request protocol:
  - A requester holds req_valid and its fields until req_ready.
  - Dropping req_valid before grant is legal and loses no state.
  - Asserting req_valid while a transaction is outstanding just waits.
- At most one outstanding transaction; never back-to-back Transfer without an intervening RESP.

Decomposition:
- Package apb_sched_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Default base/REGION_BITS constants.
  - Slave index constants GPIO_IDX=0, UART_IDX=1.
- Sub-module rr_arbiter: REQ_NUM-wide round-robin grant (req vector, advance enable, one-hot grant, encoded index).
- Decode and FSM stay in the top.

Test Plan:
- Single write, req0, addr 0x0000_0004, data 0xFF000F00, strb 0xF, PREADY=1 → Transfer 1 cycle, SEL_in=2'b01, WRITE_in=1, rsp_valid[0] at cycle 4, rsp_err=0.
- Read, req1, addr 0x0000_1008, DATA_out=500, PREADY low 3 cycles → SEL_in=2'b10, STROB_in=0, rsp_valid[1] 3 cycles later than baseline, rsp_rdata=500.
- req0 and req1 held continuously for 4 transactions → grants 0,1,0,1; no back-to-back Transfer.
- Address 0x0000_2000 → no Transfer, rsp_valid at cycle 1, rsp_err=1, rsp_rdata=0.
- SLVERR_out=1 with PENABLE&&PREADY → rsp_err=1 to the owner.
- PRESET asserted during WAIT → next cycle all outputs 0, no rsp_valid; req0 re-granted first after reset.

Source files
------------

// File: rtl/apb_sched_pkg.sv
// apb_sched_pkg: shared types and constants for the APB request scheduler.
// Holds the FSM state encoding, default slave windows and slave indices.
package apb_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int unsigned DEF_REGION_BITS = 12;
   localparam logic [31:0] DEF_GPIO_BASE   = 32'h0000_0000;
   localparam logic [31:0] DEF_UART_BASE   = 32'h0000_1000;

   localparam int unsigned GPIO_IDX = 0;
   localparam int unsigned UART_IDX = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin grant with a rotating priority pointer.
// Ports: clk_i/rst_i (sync, active high), req_i, adv_i (grant taken),
//        gnt_o (one-hot), idx_o (encoded winner).
module rr_arbiter #(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req_i,
   input  logic          adv_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] k;
   logic          found;

   // First requester at or after the pointer, wrapping upward.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      k     = '0;
      for (int unsigned o = 0; o < N; o++) begin
         k = IW'((32'(ptr_q) + o) % N);
         if (!found && req_i[k]) begin
            found    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/apb_req_scheduler.sv
// apb_req_scheduler: shares one APB_bus command port among REQ_NUM requesters.
// Ports: req_* (requester side), rsp_* (shared response), *_in/Transfer
//        (APB_bus command), PENABLE/PREADY/DATA_out/SLVERR_out (monitor).
module apb_req_scheduler
   import apb_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned STROBE_WIDTH = 4,
   parameter int unsigned SLAVES_NUM   = 2,
   parameter int unsigned REQ_NUM      = 2,
   parameter int unsigned REGION_BITS  = DEF_REGION_BITS,
   parameter logic [ADDR_WIDTH-1:0] GPIO_BASE = DEF_GPIO_BASE,
   parameter logic [ADDR_WIDTH-1:0] UART_BASE = DEF_UART_BASE
) (
   input  logic                            PCLK,
   input  logic                            PRESET,
   input  logic [REQ_NUM-1:0]              req_valid,
   output logic [REQ_NUM-1:0]              req_ready,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0]   req_addr,
   input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_wdata,
   input  logic [REQ_NUM-1:0]              req_write,
   input  logic [REQ_NUM*STROBE_WIDTH-1:0] req_strb,
   input  logic [REQ_NUM*3-1:0]            req_prot,
   output logic [REQ_NUM-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic                            rsp_err,
   output logic [ADDR_WIDTH-1:0]           ADDR_in,
   output logic [DATA_WIDTH-1:0]           DATA_in,
   output logic [2:0]                      PROT_in,
   output logic [SLAVES_NUM-1:0]           SEL_in,
   output logic [STROBE_WIDTH-1:0]         STROB_in,
   output logic                            WRITE_in,
   output logic                            Transfer,
   input  logic                            PENABLE,
   input  logic                            PREADY,
   input  logic [DATA_WIDTH-1:0]           DATA_out,
   input  logic                            SLVERR_out
);

   localparam int unsigned IDXW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   logic [REQ_NUM-1:0]      gnt;
   logic [IDXW-1:0]         gidx;
   logic                    grant_en;
   logic                    busy;

   logic [ADDR_WIDTH-1:0]   g_addr;
   logic [DATA_WIDTH-1:0]   g_wdata;
   logic [STROBE_WIDTH-1:0] g_strb;
   logic [2:0]              g_prot;
   logic                    g_write;
   logic [SLAVES_NUM-1:0]   g_sel;

   state_t                  state_q;
   logic [IDXW-1:0]         own_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STROBE_WIDTH-1:0] strb_q;
   logic [2:0]              prot_q;
   logic                    write_q;
   logic [SLAVES_NUM-1:0]   sel_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;

   assign grant_en = (state_q == ST_IDLE) && (|req_valid) && !PRESET;

   rr_arbiter #(.N(REQ_NUM)) u_arb (
      .clk_i (PCLK),
      .rst_i (PRESET),
      .req_i (req_valid),
      .adv_i (grant_en),
      .gnt_o (gnt),
      .idx_o (gidx)
   );

   assign req_ready = grant_en ? gnt : '0;

   // Winner's fields and the window it falls in.
   always_comb begin
      g_addr  = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      g_wdata = req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      g_strb  = req_strb[int'(gidx)*STROBE_WIDTH +: STROBE_WIDTH];
      g_prot  = req_prot[int'(gidx)*3 +: 3];
      g_write = req_write[gidx];
      g_sel   = '0;
      g_sel[GPIO_IDX] = g_addr[ADDR_WIDTH-1:REGION_BITS] ==
                        GPIO_BASE[ADDR_WIDTH-1:REGION_BITS];
      g_sel[UART_IDX] = g_addr[ADDR_WIDTH-1:REGION_BITS] ==
                        UART_BASE[ADDR_WIDTH-1:REGION_BITS];
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= ST_IDLE;
         own_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         write_q <= 1'b0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|req_valid) begin
                  own_q   <= gidx;
                  addr_q  <= g_addr;
                  // Reads present zero data and strobes on the bus.
                  wdata_q <= g_write ? g_wdata : '0;
                  strb_q  <= g_write ? g_strb : '0;
                  prot_q  <= g_prot;
                  write_q <= g_write;
                  sel_q   <= g_sel;
                  rdata_q <= '0;
                  if (|g_sel) begin
                     err_q   <= 1'b0;
                     state_q <= ST_ISSUE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (PENABLE && PREADY) begin
                  rdata_q <= write_q ? '0 : DATA_out;
                  err_q   <= SLVERR_out;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign Transfer = (state_q == ST_ISSUE);
   assign SEL_in   = busy ? sel_q : '0;
   assign ADDR_in  = addr_q;
   assign DATA_in  = wdata_q;
   assign PROT_in  = prot_q;
   assign STROB_in = strb_q;
   assign WRITE_in = write_q;

   always_comb begin
      rsp_valid = '0;
      if (state_q == ST_RESP) begin
         rsp_valid[own_q] = 1'b1;
      end
   end

   assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
   assign rsp_err   = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// tb_apb_req_scheduler: directed bench with a transaction-level model.
// Emulates the APB_bus handshake and compares every cycle.
module tb_apb_req_scheduler;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int N  = 2;

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]  req_write = '0;
   logic [N*SW-1:0] req_strb = '0;
   logic [N*3-1:0]  req_prot = '0;
   logic [N-1:0]  rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] ADDR_in;
   logic [DW-1:0] DATA_in;
   logic [2:0]    PROT_in;
   logic [1:0]    SEL_in;
   logic [SW-1:0] STROB_in;
   logic          WRITE_in;
   logic          Transfer;
   logic          PENABLE = 1'b0;
   logic          PREADY = 1'b0;
   logic [DW-1:0] DATA_out = '0;
   logic          SLVERR_out = 1'b0;

   apb_req_scheduler dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_write  (req_write),
      .req_strb   (req_strb),
      .req_prot   (req_prot),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .ADDR_in    (ADDR_in),
      .DATA_in    (DATA_in),
      .PROT_in    (PROT_in),
      .SEL_in     (SEL_in),
      .STROB_in   (STROB_in),
      .WRITE_in   (WRITE_in),
      .Transfer   (Transfer),
      .PENABLE    (PENABLE),
      .PREADY     (PREADY),
      .DATA_out   (DATA_out),
      .SLVERR_out (SLVERR_out)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc++;

   int n_chk = 0;
   int n_err = 0;

   function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, a, e, cyc);
      end
   endfunction

   // APB_bus emulation: setup after Transfer, then access with wait states.
   int          sl_ws = 0;
   logic [31:0] sl_rdata = '0;
   logic        sl_err = 1'b0;
   int          ph = 0;
   int          cnt = 0;
   logic        tr_s = 1'b0;
   logic        rst_s = 1'b1;

   always @(posedge PCLK) begin
      #1;
      if (rst_s) begin
         ph = 0;
         PENABLE = 1'b0;
         PREADY = 1'b0;
      end else if (ph == 0) begin
         if (tr_s) ph = 1;
      end else if (ph == 1) begin
         ph = 2;
         PENABLE = 1'b1;
         cnt = sl_ws;
         PREADY = (cnt == 0);
         DATA_out = sl_rdata;
         SLVERR_out = sl_err;
      end else begin
         if (PREADY) begin
            ph = 0;
            PENABLE = 1'b0;
            PREADY = 1'b0;
            SLVERR_out = 1'b0;
         end else begin
            cnt--;
            PREADY = (cnt == 0);
         end
      end
   end

   // Model state: one outstanding transaction with event times.
   bit          m_busy = 0;
   bit          m_hit = 0;
   bit          m_zero = 1;
   bit          m_write = 0;
   int          m_own = 0;
   int          m_tg = 0;
   int          m_rsp = -1;
   int          m_ptr = 0;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_strb;
   logic [2:0]  m_prot;
   logic [1:0]  m_sel;
   logic        m_err;

   // Observations for the hand-computed checks.
   int          obs_g[$];
   int          obs_gc[$];
   int          obs_rsp_n = 0;
   int          obs_rsp_cyc = 0;
   int          obs_rsp_own = 0;
   logic [31:0] obs_rdata;
   logic        obs_err;
   int          n_xfer = 0;
   int          obs_xfer_cyc = 0;
   logic [1:0]  obs_sel;
   logic [3:0]  obs_strb;
   logic        obs_wr;

   logic [1:0]  e_rdy;
   bit          win;
   bit          rspv;
   int          c;
   int          g;
   logic [31:0] a;

   always @(negedge PCLK) begin
      c = cyc;
      tr_s = Transfer;
      rst_s = PRESET;
      e_rdy = '0;
      if (!m_busy && !PRESET) begin
         for (int o = 0; o < N; o++) begin
            g = (m_ptr + o) % N;
            if (e_rdy == 0 && req_valid[g]) e_rdy[g] = 1'b1;
         end
      end
      win = m_busy && m_hit && c >= m_tg + 1 && (m_rsp < 0 || c < m_rsp);
      rspv = m_busy && c == m_rsp;
      if (c >= 2) begin
         chk("req_ready", 64'(req_ready), 64'(e_rdy));
         chk("Transfer", 64'(Transfer), 64'(m_busy && m_hit && c == m_tg + 1));
         chk("SEL_in", 64'(SEL_in), win ? 64'(m_sel) : 64'd0);
         chk("rsp_valid", 64'(rsp_valid), rspv ? 64'(1 << m_own) : 64'd0);
         if (rspv) begin
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            chk("rsp_err", 64'(rsp_err), 64'(m_err));
         end
         if (win) begin
            chk("ADDR_in", 64'(ADDR_in), 64'(m_addr));
            chk("WRITE_in", 64'(WRITE_in), 64'(m_write));
            chk("PROT_in", 64'(PROT_in), 64'(m_prot));
            chk("DATA_in", 64'(DATA_in), m_write ? 64'(m_wdata) : 64'd0);
            chk("STROB_in", 64'(STROB_in), m_write ? 64'(m_strb) : 64'd0);
         end else if (m_zero) begin
            chk("rst_cmd", {ADDR_in, DATA_in}, 64'd0);
            chk("rst_misc", 64'({PROT_in, STROB_in, WRITE_in, rsp_err}), 64'd0);
         end
      end
      if (req_ready != 0) begin
         obs_g.push_back(req_ready[1] ? 1 : 0);
         obs_gc.push_back(c);
      end
      if (rsp_valid != 0) begin
         obs_rsp_n++;
         obs_rsp_cyc = c;
         obs_rsp_own = rsp_valid[1] ? 1 : 0;
         obs_rdata = rsp_rdata;
         obs_err = rsp_err;
      end
      if (Transfer) begin
         n_xfer++;
         obs_xfer_cyc = c;
         obs_sel = SEL_in;
         obs_strb = STROB_in;
         obs_wr = WRITE_in;
      end
      if (PRESET) begin
         m_busy = 0;
         m_ptr = 0;
         m_zero = 1;
      end else if (!m_busy) begin
         if (e_rdy != 0) begin
            g = e_rdy[1] ? 1 : 0;
            a = req_addr[g*AW +: AW];
            m_busy = 1;
            m_zero = 0;
            m_own = g;
            m_tg = c;
            m_ptr = (g + 1) % N;
            m_addr = a;
            m_wdata = req_wdata[g*DW +: DW];
            m_strb = req_strb[g*SW +: SW];
            m_prot = req_prot[g*3 +: 3];
            m_write = req_write[g];
            if (a / 4096 == 0) m_sel = 2'b01;
            else if (a / 4096 == 1) m_sel = 2'b10;
            else m_sel = 2'b00;
            m_hit = (m_sel != 0);
            m_rsp = m_hit ? -1 : c + 1;
            m_rdata = '0;
            m_err = !m_hit;
         end
      end else if (c == m_rsp) begin
         m_busy = 0;
      end else if (m_hit && m_rsp < 0 && c >= m_tg + 2 && PENABLE && PREADY) begin
         m_rsp = c + 1;
         m_rdata = m_write ? '0 : DATA_out;
         m_err = SLVERR_out;
      end
   end

   int t0;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_req(int i, logic [31:0] ad, logic [31:0] d, logic w,
                          logic [3:0] s, logic [2:0] p);
      req_addr[i*AW +: AW] = ad;
      req_wdata[i*DW +: DW] = d;
      req_write[i] = w;
      req_strb[i*SW +: SW] = s;
      req_prot[i*3 +: 3] = p;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_grants(int n);
      int k = 0;
      while (obs_g.size() < n && k < 200) begin
         tick();
         k++;
      end
      chk("grant_wait", 64'(obs_g.size()), 64'(n));
   endtask

   task automatic wait_rsps(int n);
      int k = 0;
      while (obs_rsp_n < n && k < 200) begin
         tick();
         k++;
      end
      chk("rsp_wait", 64'(obs_rsp_n), 64'(n));
   endtask

   task automatic run_one(int i, logic [31:0] ad, logic [31:0] d, logic w,
                          logic [3:0] s, int ws, logic [31:0] rd, logic se);
      int g0;
      int r0;
      g0 = obs_g.size();
      r0 = obs_rsp_n;
      sl_ws = ws;
      sl_rdata = rd;
      sl_err = se;
      tick();
      set_req(i, ad, d, w, s, 3'b010);
      t0 = cyc;
      wait_grants(g0 + 1);
      req_valid[i] = 1'b0;
      wait_rsps(r0 + 1);
   endtask

   int x0;
   int g0;
   int r0;

   initial begin
      tick();
      tick();
      PRESET = 1'b0;
      tick();
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_sel", 64'(SEL_in), 64'd0);

      // Single write to GPIO.
      x0 = n_xfer;
      run_one(0, 32'h0000_0004, 32'hFF00_0F00, 1'b1, 4'hF, 0, 32'd0, 1'b0);
      chk("t1_grant_cyc", 64'(obs_gc[$]), 64'(t0));
      chk("t1_xfer_cyc", 64'(obs_xfer_cyc), 64'(t0 + 1));
      chk("t1_xfer_cnt", 64'(n_xfer - x0), 64'd1);
      chk("t1_sel", 64'(obs_sel), 64'b01);
      chk("t1_write", 64'(obs_wr), 64'd1);
      chk("t1_rsp_cyc", 64'(obs_rsp_cyc), 64'(t0 + 4));
      chk("t1_rsp_own", 64'(obs_rsp_own), 64'd0);
      chk("t1_rsp_err", 64'(obs_err), 64'd0);

      // Read from UART with three wait states.
      run_one(1, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 4'hF, 3, 32'd500, 1'b0);
      chk("t2_sel", 64'(obs_sel), 64'b10);
      chk("t2_strb", 64'(obs_strb), 64'd0);
      chk("t2_rsp_cyc", 64'(obs_rsp_cyc), 64'(t0 + 7));
      chk("t2_rsp_own", 64'(obs_rsp_own), 64'd1);
      chk("t2_rdata", 64'(obs_rdata), 64'd500);

      // Both requesters held for four transactions.
      g0 = obs_g.size();
      r0 = obs_rsp_n;
      x0 = n_xfer;
      sl_ws = 0;
      sl_rdata = 32'h0000_0077;
      sl_err = 1'b0;
      tick();
      set_req(0, 32'h0000_0010, 32'h1234_5678, 1'b1, 4'h3, 3'b001);
      set_req(1, 32'h0000_1004, 32'h0, 1'b0, 4'hC, 3'b100);
      wait_grants(g0 + 4);
      req_valid = '0;
      wait_rsps(r0 + 4);
      chk("t3_g0", 64'(obs_g[g0]), 64'd0);
      chk("t3_g1", 64'(obs_g[g0 + 1]), 64'd1);
      chk("t3_g2", 64'(obs_g[g0 + 2]), 64'd0);
      chk("t3_g3", 64'(obs_g[g0 + 3]), 64'd1);
      for (int k = 1; k < 4; k++) begin
         chk("t3_gap", 64'(obs_gc[g0 + k] - obs_gc[g0 + k - 1]), 64'd5);
      end
      chk("t3_xfers", 64'(n_xfer - x0), 64'd4);

      // Decode miss.
      x0 = n_xfer;
      run_one(0, 32'h0000_2000, 32'h0, 1'b0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0);
      chk("t4_rsp_cyc", 64'(obs_rsp_cyc), 64'(t0 + 1));
      chk("t4_err", 64'(obs_err), 64'd1);
      chk("t4_rdata", 64'(obs_rdata), 64'd0);
      chk("t4_no_xfer", 64'(n_xfer - x0), 64'd0);
      repeat (2) tick();

      // Slave error.
      run_one(1, 32'h0000_1010, 32'hA5A5_A5A5, 1'b1, 4'hF, 1, 32'd0, 1'b1);
      chk("t5_err", 64'(obs_err), 64'd1);
      chk("t5_own", 64'(obs_rsp_own), 64'd1);

      // Reset during WAIT.
      g0 = obs_g.size();
      r0 = obs_rsp_n;
      sl_ws = 10;
      sl_rdata = 32'd9;
      sl_err = 1'b0;
      tick();
      set_req(1, 32'h0000_0008, 32'h0, 1'b0, 4'h0, 3'b000);
      wait_grants(g0 + 1);
      req_valid = '0;
      tick();
      tick();
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      chk("t6_rst_sel", 64'(SEL_in), 64'd0);
      chk("t6_rst_xfer", 64'(Transfer), 64'd0);
      repeat (12) tick();
      chk("t6_no_rsp", 64'(obs_rsp_n), 64'(r0));
      sl_ws = 0;
      g0 = obs_g.size();
      set_req(0, 32'h0000_0004, 32'h0, 1'b0, 4'h0, 3'b000);
      set_req(1, 32'h0000_1000, 32'h0, 1'b0, 4'h0, 3'b000);
      wait_grants(g0 + 1);
      req_valid = '0;
      chk("t6_first_grant", 64'(obs_g[g0]), 64'd0);
      wait_rsps(r0 + 1);
      chk("t6_rsp_own", 64'(obs_rsp_own), 64'd0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
